stop_watch_ctrl: RTL



---
 rtl/stop_watch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stop_watch_ctrl.sv
// Stop-watch control front-end: per-button debounce, IDLE/RUN/PAUSE/LAP FSM and tick prescaler.
// Define STOP_WATCH_LAP_EN to enable the LAP state, the lap debouncer and lap_hold.

module stop_watch_ctrl_deb #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic Clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_prev_q;
  logic             evt_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter measures how long the synchronized level has disagreed with the accepted level.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      evt_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      evt_q         <= stable_q & ~stable_prev_q;
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign evt_o = evt_q;
endmodule

module stop_watch_ctrl #(
  parameter int DEB_CYCLES = 1000,
  parameter int TICK_DIV   = 100,
  parameter int PRE_W      = 16
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       run,
  output logic       tick,
  output logic       clr,
  output logic       lap_hold,
  output logic [1:0] state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic ss_evt, clr_evt, lap_evt;

  stop_watch_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .Clk(Clk), .rst(rst), .btn_i(btn_start_stop), .evt_o(ss_evt)
  );
  stop_watch_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .Clk(Clk), .rst(rst), .btn_i(btn_clear), .evt_o(clr_evt)
  );
`ifdef STOP_WATCH_LAP_EN
  stop_watch_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .Clk(Clk), .rst(rst), .btn_i(btn_lap), .evt_o(lap_evt)
  );
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_evt        = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic             run_q, run_d;
  logic             lap_hold_q, lap_hold_d;
  logic             clr_q, take_clr;
  logic             tick_q;
  logic [PRE_W-1:0] pre_q;
  logic             pre_wrap;

  // Priority clear > start_stop > lap; an event not valid in the current state falls through.
  always_comb begin
    state_d  = state_q;
    take_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_evt)     take_clr = 1'b1;
        else if (ss_evt) state_d  = S_RUN;
      end
      S_RUN: begin
        if (ss_evt)       state_d = S_PAUSE;
        else if (lap_evt) state_d = S_LAP;
      end
      S_PAUSE: begin
        if (clr_evt) begin
          state_d  = S_IDLE;
          take_clr = 1'b1;
        end else if (ss_evt) begin
          state_d = S_RUN;
        end
      end
      S_LAP: begin
        if (ss_evt)       state_d = S_PAUSE;
        else if (lap_evt) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run_d = (state_d == S_RUN) || (state_d == S_LAP);
`ifdef STOP_WATCH_LAP_EN
  assign lap_hold_d = (state_d == S_LAP);
`else
  assign lap_hold_d = 1'b0;
`endif
  assign pre_wrap = (pre_q == PRE_LAST);

  // Prescaler advances only on edges where counting continues, so tick never lands in PAUSE/IDLE.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      lap_hold_q <= 1'b0;
      clr_q      <= 1'b0;
      tick_q     <= 1'b0;
      pre_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      lap_hold_q <= lap_hold_d;
      clr_q      <= take_clr;
      tick_q     <= run_q & run_d & pre_wrap;
      if (take_clr) begin
        pre_q <= '0;
      end else if (run_q && run_d) begin
        pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      end
    end
  end

  assign state    = state_q;
  assign run      = run_q;
  assign lap_hold = lap_hold_q;
  assign clr      = clr_q;
  assign tick     = tick_q;
endmodule
